branch_predictor: RTL

- IF-stage dynamic predictor. It supplies the predicted next PC (pc_pre) for the fetch PC.
- It consumes branch resolution from EX: the branch flag, the resolved next_pc and the mispredict flag (jump_rst).
- Structure: direct-mapped branch target buffer (BTB), one 2-bit saturating counter per entry.
- Also keeps branch and mispredict statistics counters for the debug display.

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_predictor_btb_entry_array.sv | 89 ++++++++
 rtl/branch_predictor.sv | 87 ++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: PC step, 2-bit counter
// encodings and the saturating counter update.
package branch_predictor_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned CTR_W  = 2;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  // Two-bit confidence counter states
  localparam logic [CTR_W-1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [CTR_W-1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [CTR_W-1:0] WT  = 2'b10;  // weakly taken
  localparam logic [CTR_W-1:0] ST  = 2'b11;  // strongly taken

  // Saturating step toward taken (increment) or not-taken (decrement)
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                input logic            taken);
    logic [CTR_W-1:0] res;
    if (taken) res = (ctr == ST)  ? ST  : ctr + CTR_W'(1);
    else       res = (ctr == SNT) ? SNT : ctr - CTR_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_entry_array.sv
// Direct-mapped BTB storage: valid/tag/target/counter per entry.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears every field)
//   rd_idx_i        fetch lookup index; rd_*_o return that entry (combinational)
//   wr_en_i         apply one resolved branch at wr_idx_i this edge
//   wr_tag_i        tag of the resolved branch PC
//   wr_taken_i      branch resolved taken
//   wr_target_i     resolved target, written on taken
module btb_entry_array
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 3,
  localparam int unsigned TAG_W = PC_W - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [PC_W-1:0]  rd_target_o,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_taken_i,
  input  logic [PC_W-1:0]  wr_target_i
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic             ent_we;
  logic             ent_valid_d;
  logic [TAG_W-1:0] ent_tag_d;
  logic [PC_W-1:0]  ent_target_d;
  logic [CTR_W-1:0] ent_ctr_d;
  logic             wr_hit;

  // Read port shows pre-edge contents; no write bypass
  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_ctr_o    = ctr_q[rd_idx_i];

  // Next contents of the single entry addressed by the write port
  always_comb begin
    ent_we       = 1'b0;
    ent_valid_d  = valid_q[wr_idx_i];
    ent_tag_d    = tag_q[wr_idx_i];
    ent_target_d = target_q[wr_idx_i];
    ent_ctr_d    = ctr_q[wr_idx_i];
    wr_hit       = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);
    if (wr_en_i) begin
      if (wr_hit) begin
        ent_we    = 1'b1;
        ent_ctr_d = ctr_step(ctr_q[wr_idx_i], wr_taken_i);
        if (wr_taken_i) ent_target_d = wr_target_i;
      end else if (wr_taken_i) begin
        // Allocate (or evict an alias) as weakly taken
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = wr_tag_i;
        ent_target_d = wr_target_i;
        ent_ctr_d    = WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= SNT;
      end
    end else if (ent_we) begin
      valid_q[wr_idx_i]  <= ent_valid_d;
      tag_q[wr_idx_i]    <= ent_tag_d;
      target_q[wr_idx_i] <= ent_target_d;
      ctr_q[wr_idx_i]    <= ent_ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: BTB lookup gives the next fetch PC,
// EX resolutions train the BTB, and branch/mispredict counts are kept.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   halt                        freezes BTB and counters (lookup stays live)
//   pc_if -> pc_pre, pred_hit   combinational prediction for the fetch PC
//   upd_en, upd_pc, upd_next_pc, upd_mispredict   EX resolution
//   branch_cnt, mispred_cnt     statistics, wrap at 2^CNT_W
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc_if,
  output logic [PC_W-1:0]  pc_pre,
  output logic             pred_hit,
  input  logic             upd_en,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [PC_W-1:0]  upd_next_pc,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [PC_W-1:0]  rd_target;
  logic [CTR_W-1:0] rd_ctr;
  logic             lk_hit;
  logic             upd_fire;
  logic             upd_taken;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign upd_fire  = upd_en && !halt;
  // Anything other than fall-through counts as taken
  assign upd_taken = (upd_next_pc != upd_pc + PC_INC);

  btb_entry_array #(.IDX_W(IDX_W)) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (pc_if[IDX_W+1:2]),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_target_o (rd_target),
    .rd_ctr_o    (rd_ctr),
    .wr_en_i     (upd_fire),
    .wr_idx_i    (upd_pc[IDX_W+1:2]),
    .wr_tag_i    (upd_pc[PC_W-1:IDX_W+2]),
    .wr_taken_i  (upd_taken),
    .wr_target_i (upd_next_pc)
  );

  // Prediction mux: redirect only on a hit with a taken-side counter
  assign lk_hit   = rd_valid && (rd_tag == pc_if[PC_W-1:IDX_W+2]);
  assign pred_hit = lk_hit;
  assign pc_pre   = (lk_hit && (rd_ctr >= WT)) ? rd_target : pc_if + PC_INC;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_fire) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (upd_mispredict) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
